piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Upstream serializer for the SISO shift-register chain. Accepts a DW-bit parallel word over a valid/ready handshake and emits it MSB-first as a serial bit stream (`ser_o`) with a one-cycle shift strobe (`ser_enb_o`) per bit. The strobe drives the downstream SISO's `enb`, and `ser_o` drives its `inp`. A programmable bit-period divider sets the spacing between strobes.

## Interface
- `DW`, default 4: word width and bits per frame; legal range DW ≥ 2.
- `DIV`, default 1: clock cycles per serial bit; legal range DIV ≥ 1; DIV = 1 gives one bit every cycle.

- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset; the polarity and synchronicity are fixed.
- `data_i`  in  DW  parallel word; sampled only on the handshake edge.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  block can accept a word; high only in IDLE.
- `ser_o`  out  1  serial data = MSB of the internal shift register.
- `ser_enb_o`  out  1  one-cycle strobe; downstream shifts `ser_o` in on this cycle.
- `busy_o`  out  1  high in SHIFT and DONE.
- `done_o`  out  1  one-cycle pulse after the last bit of a frame.

## Operation
- State machine states: IDLE, SHIFT, DONE. All state is registered. Outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE:
  - `ready_o` = 1.
  - On `valid_i & ready_o` at an edge: `shreg` ← `data_i`, `bit_cnt` ← 0, `div_cnt` ← 0, next state SHIFT.
  - Otherwise hold state.
- SHIFT:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - When `div_cnt` == DIV-1:
    - `ser_enb_o` = 1 this cycle.
    - At the edge, `shreg` ← {`shreg`[DW-2:0], 1'b0} and `bit_cnt` increments.
  - When the DW-th strobe occurs (`bit_cnt` == DW-1 at a strobe), next state DONE.
- DONE:
  - `done_o` = 1 and `ready_o` = 0 for exactly one cycle.
  - Next state IDLE unconditionally.
- `ser_o` = `shreg`[DW-1] in every state. It is 0 in IDLE after reset and 0 after a completed frame, because zeros are shifted in.
- `valid_i` outside IDLE is ignored; the word is not captured and not queued. Upstream must hold `valid_i` until `ready_o`.
- Counter widths:
  - `div_cnt` is max(1, $clog2(DIV)) bits.
  - `bit_cnt` is $clog2(DW+1) bits.
  - No overflow is possible within legal parameters.
- `rst`: state ← IDLE, `shreg` ← 0, `bit_cnt` ← 0, `div_cnt` ← 0. Reset wins over the handshake on the same edge.

## Timing
- Reset values, in the cycle after a `rst` edge:
  - `ready_o` = 1
  - `ser_o` = 0
  - `ser_enb_o` = 0
  - `busy_o` = 0
  - `done_o` = 0
- Cycle numbering: the handshake edge ends cycle T.
  - `ready_o` and `busy_o` change from cycle T+1 onward.
  - Strobe k (k = 1..DW) is in cycle T+k·DIV. `ser_o` in that cycle equals `data_i`[DW-k] as captured.
  - `done_o` is in cycle T+DW·DIV+1.
  - `ready_o` returns to 1 in cycle T+DW·DIV+2.
- Frame-to-frame minimum spacing is DW·DIV+2 cycles.
- Reset mid-frame aborts immediately. No `ser_enb_o` and no `done_o` after the reset edge, and the partial frame is discarded.
- `ser_o` is stable for the full bit period and is valid at every strobe.

## Test plan
- Reset then idle, DW=4, DIV=1: hold `rst` 2 cycles, then release → `ready_o`=1, `ser_o`=0, `ser_enb_o`=0, `busy_o`=0, `done_o`=0. No strobes over 10 idle cycles.
- Single frame, DW=4, DIV=1, `data_i`=4'b1011 accepted at T:
  - Strobes in cycles T+1..T+4 with `ser_o` = 1, 0, 1, 1.
  - `done_o` in T+5; `ready_o` in T+6.
  - A chained SISO (DW=4) then holds 4'b1011.
- Divider, DW=4, DIV=3, `data_i`=4'b0110:
  - Strobes only in cycles T+3, T+6, T+9, T+12 with `ser_o` = 0, 1, 1, 0.
  - `ser_o` is constant between strobes.
- Ignored request: while busy, toggle `valid_i` with `data_i`=4'hF → current frame bits are unchanged and no second frame starts. Holding `valid_i` high through DONE causes 4'hF to be accepted on the first IDLE cycle.
- Back-to-back frames, DW=4, DIV=1, `valid_i` held high with 4'b1000 then 4'b0001 → frames start exactly 6 cycles apart. The strobe pattern is 1,0,0,0, then a 2-cycle gap, then 0,0,0,1.
- Reset mid-frame: assert `rst` for 1 cycle after the 2nd strobe of 4'b1111 → no further strobes, no `done_o`, `ser_o`=0, `ready_o`=1 the following cycle.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmitter: accepts a DW-bit word over valid/ready and emits it MSB-first
// with a one-cycle shift strobe every DIV clock cycles, followed by a one-cycle done pulse.
module piso_tx_ctrl #(
  parameter int unsigned DW  = 4,
  parameter int unsigned DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          ser_o,
  output logic          ser_enb_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCW = $clog2(DW + 1);

  localparam logic [DCW-1:0] DivMax = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BitMax = BCW'(DW - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    strobe    = (state_q == StShift) && (div_cnt_q == DivMax);

    case (state_q)
      StIdle: begin
        if (valid_i) begin
          shreg_d   = data_i;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (strobe) begin
          // Zeros are shifted in so ser_o rests low once the frame has drained.
          shreg_d   = {shreg_q[DW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          div_cnt_d = '0;
          if (bit_cnt_q == BitMax) begin
            state_d = StDone;
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs come straight from registers; no input reaches an output combinationally.
  assign ready_o   = (state_q == StIdle);
  assign busy_o    = (state_q == StShift) || (state_q == StDone);
  assign done_o    = (state_q == StDone);
  assign ser_enb_o = strobe;
  assign ser_o     = shreg_q[DW-1];

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: one instance at DIV=1 and one at DIV=3, checked cycle by cycle.
module tb_piso_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data1 = '0, data3 = '0;
  logic       valid1 = 1'b0, valid3 = 1'b0;
  logic       ready1, ser1, enb1, busy1, done1;
  logic       ready3, ser3, enb3, busy3, done3;
  logic [3:0] siso1;
  logic [4:0] o1, o3, e;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.DW(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
    .ser_o(ser1), .ser_enb_o(enb1), .busy_o(busy1), .done_o(done1)
  );

  piso_tx_ctrl #(.DW(4), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .data_i(data3), .valid_i(valid3), .ready_o(ready3),
    .ser_o(ser3), .ser_enb_o(enb3), .busy_o(busy3), .done_o(done3)
  );

  // Downstream SISO chain fed by dut1.
  always @(posedge clk) begin
    if (rst) siso1 <= '0;
    else if (enb1) siso1 <= {siso1[2:0], ser1};
  end

  assign o1 = {ready1, busy1, done1, enb1, ser1};
  assign o3 = {ready3, busy3, done3, enb3, ser3};

  // Expected {ready, busy, done, strobe, ser} in cycle T+c of a frame carrying d.
  function automatic logic [4:0] frame_exp(input int c, input logic [3:0] d, input int div);
    int k;
    if (c <= 4 * div) begin
      k = (c + div - 1) / div;
      return {1'b0, 1'b1, 1'b0, (c % div) == 0, d[4-k]};
    end else if (c == 4 * div + 1) begin
      return 5'b01100;
    end
    return 5'b10000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (o1 !== 5'b10000) begin
        errors++;
        $display("FAIL reset_idle_div1 cyc=%0d got=%b exp=10000", i, o1);
      end
      checks++;
      if (o3 !== 5'b10000) begin
        errors++;
        $display("FAIL reset_idle_div3 cyc=%0d got=%b exp=10000", i, o3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_frame();
    logic [4:0] tbl [1:6];
    tbl[1] = 5'b01011; tbl[2] = 5'b01010; tbl[3] = 5'b01011;
    tbl[4] = 5'b01011; tbl[5] = 5'b01100; tbl[6] = 5'b10000;
    data1  = 4'b1011;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (o1 !== tbl[c]) begin
        errors++;
        $display("FAIL single_frame c=%0d got=%b exp=%b", c, o1, tbl[c]);
      end
      @(negedge clk);
    end
    checks++;
    if (siso1 !== 4'b1011) begin
      errors++;
      $display("FAIL single_frame_siso got=%b exp=1011", siso1);
    end
  endtask

  task automatic test_divider();
    data3  = 4'b0110;
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      e = frame_exp(c, 4'b0110, 3);
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL divider c=%0d got=%b exp=%b", c, o3, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_request();
    data1  = 4'b0101;
    valid1 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      e = (c <= 6) ? frame_exp(c, 4'b0101, 1) : frame_exp(c - 6, 4'hF, 1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL ignored_request c=%0d got=%b exp=%b", c, o1, e);
      end
      data1 = 4'hF;
      if (c <= 4) valid1 = c[0];
      else if (c <= 6) valid1 = 1'b1;
      else valid1 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (siso1 !== 4'hF) begin
      errors++;
      $display("FAIL ignored_request_siso got=%b exp=1111", siso1);
    end
  endtask

  task automatic test_back_to_back();
    data1  = 4'b1000;
    valid1 = 1'b1;
    @(negedge clk);
    data1 = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      e = (c <= 6) ? frame_exp(c, 4'b1000, 1) : frame_exp(c - 6, 4'b0001, 1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, o1, e);
      end
      if (c >= 7) valid1 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (siso1 !== 4'b0001) begin
      errors++;
      $display("FAIL back_to_back_siso got=%b exp=0001", siso1);
    end
  endtask

  task automatic test_reset_mid_frame();
    data1  = 4'b1111;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      e = frame_exp(c, 4'b1111, 1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, o1, e);
      end
      if (c == 2) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      checks++;
      if (o1 !== 5'b10000) begin
        errors++;
        $display("FAIL reset_mid_post c=%0d got=%b exp=10000", c, o1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_divider();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
